// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data width, default bit period, parity helper.
// Parity support in the transmitter is enabled with the UART_TX_PARITY_EN macro.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 52;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tx_bps_module.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, pulses bit_tick on the wrap.
// Held at zero whenever run is low, so each frame starts on a full bit period (UART_TX_PARITY_EN-agnostic).
module tx_bps_module
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx_module.sv
// UART transmitter: start, 8 data bits LSB-first, optional even parity (UART_TX_PARITY_EN), STOP_BITS stops.
// Line drops the cycle after an accepted request; requests while busy are dropped, one-cycle done pulse in IDLE.
module uart_tx_module
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   TX_En_Sig,
  input  logic [UART_DATA_W-1:0] TX_Data,
  output logic                   TX_Busy,
  output logic                   TX_Done_Sig,
  output logic                   TX_Pin_Out
);

  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_W - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t            state, state_nxt;
  logic [2:0]             bit_idx, bit_idx_nxt;
  logic [UART_DATA_W-1:0] shreg;
  logic                   bit_tick;
  logic                   pin_nxt, busy_nxt, done_nxt;

  tx_bps_module #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bps (
    .CLK      (CLK),
    .RST      (RST),
    .run      (state != IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      bit_idx     <= '0;
      shreg       <= '0;
      TX_Pin_Out  <= 1'b1;
      TX_Busy     <= 1'b0;
      TX_Done_Sig <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_idx     <= bit_idx_nxt;
      if (state == IDLE && TX_En_Sig) begin
        shreg <= TX_Data;
      end
      TX_Pin_Out  <= pin_nxt;
      TX_Busy     <= busy_nxt;
      TX_Done_Sig <= done_nxt;
    end
  end

  // bit_idx indexes data bits in DATA and counts stop periods in STOP
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    case (state)
      IDLE:  if (TX_En_Sig) state_nxt = START;
      START: if (bit_tick) state_nxt = DATA;
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_tick) state_nxt = STOP;
`endif
      STOP: begin
        if (bit_tick) begin
          if (bit_idx == LAST_STOP) state_nxt = IDLE;
          else bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) bit_idx_nxt = '0;
  end

  // Outputs are registered, so they are derived from where the FSM is heading
  always_comb begin
    pin_nxt  = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == STOP) && (state_nxt == IDLE);
    case (state_nxt)
      START:  pin_nxt = 1'b0;
      DATA:   pin_nxt = shreg[bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
      PARITY: pin_nxt = even_parity(shreg);
`endif
      default: pin_nxt = 1'b1;
    endcase
  end

endmodule
